// File: rtl/fa_pipe_pkg.sv
// Shared constants and types for the bit-serial-carry pipelined adder/subtractor.
package fa_pipe_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic v;
    logic sub;
    logic c;
  } slot_t;

  function automatic int lat(input int width, input int stg);
    return width * stg + 1;
  endfunction
endpackage

// File: rtl/fa_bit_slice.sv
// One registered full-adder slice. The carry is captured per slot and forced to 0
// on invalid slots, so a bubble never hands a stale carry to the next word.
module fa_bit_slice #(
  parameter int STG = 1
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic v_i,
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic v_o,
  output logic s_o,
  output logic c_o
);
  logic [STG-1:0] v_q, s_q, c_q;

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      v_q <= '0;
      s_q <= '0;
      c_q <= '0;
    end else begin
      v_q[0] <= v_i;
      s_q[0] <= v_i & (a_i ^ b_i ^ c_i);
      c_q[0] <= v_i & ((a_i & b_i) | (c_i & (a_i ^ b_i)));
      // STG=2 adds a retiming register behind the adder
      for (int k = 1; k < STG; k++) begin
        v_q[k] <= v_q[k-1];
        s_q[k] <= s_q[k-1];
        c_q[k] <= c_q[k-1];
      end
    end
  end

  assign v_o = v_q[STG-1];
  assign s_o = s_q[STG-1];
  assign c_o = c_q[STG-1];
endmodule

// File: rtl/fa_pipe_n.sv
// WIDTH-bit adder/subtractor with a clocked ripple carry: operands are skewed in,
// each bit slice resolves STG clocks after its neighbour, and the sum is deskewed out.
module fa_pipe_n
  import fa_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STG   = 1
) (
  input  logic             TI,
  input  logic             RNI,
  input  logic             VI,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             CI,
  input  logic             SUBI,
  output logic             VO,
  output logic [WIDTH-1:0] SO,
  output logic             CO,
  output logic             OVO
);
  slot_t            in_slot;
  logic             cin;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] a_sk, b_sk, s_raw, s_al, v_c, c_c;
  logic [STG-1:0]   msb_ci_dl;

  assign in_slot = '{v: VI, sub: SUBI, c: CI};
  assign cin     = (in_slot.sub == MODE_SUB) ? ~in_slot.c : in_slot.c;
  assign bx      = (in_slot.sub == MODE_SUB) ? ~BI : BI;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      localparam int DI = i * STG;
      localparam int DO = (WIDTH - 1 - i) * STG;
      logic v_in, c_in;

      if (DI == 0) begin : g_nsk
        assign a_sk[i] = AI[i];
        assign b_sk[i] = bx[i];
      end else begin : g_sk
        logic [DI-1:0] a_dl, b_dl;
        always_ff @(posedge TI) begin
          if (!RNI) begin
            a_dl <= '0;
            b_dl <= '0;
          end else begin
            a_dl[0] <= AI[i];
            b_dl[0] <= bx[i];
            for (int k = 1; k < DI; k++) begin
              a_dl[k] <= a_dl[k-1];
              b_dl[k] <= b_dl[k-1];
            end
          end
        end
        assign a_sk[i] = a_dl[DI-1];
        assign b_sk[i] = b_dl[DI-1];
      end

      // bit 0 carries the word's valid and carry-in; higher bits chain off their neighbour
      if (i == 0) begin : g_head
        assign v_in = in_slot.v;
        assign c_in = cin;
      end else begin : g_chain
        assign v_in = v_c[i-1];
        assign c_in = c_c[i-1];
      end

      fa_bit_slice #(.STG(STG)) u_slice (
        .gclk   (TI),
        .grst_n (RNI),
        .v_i    (v_in),
        .a_i    (a_sk[i]),
        .b_i    (b_sk[i]),
        .c_i    (c_in),
        .v_o    (v_c[i]),
        .s_o    (s_raw[i]),
        .c_o    (c_c[i])
      );

      if (DO == 0) begin : g_ndsk
        assign s_al[i] = s_raw[i];
      end else begin : g_dsk
        logic [DO-1:0] s_dl;
        always_ff @(posedge TI) begin
          if (!RNI) begin
            s_dl <= '0;
          end else begin
            s_dl[0] <= s_raw[i];
            for (int k = 1; k < DO; k++) s_dl[k] <= s_dl[k-1];
          end
        end
        assign s_al[i] = s_dl[DO-1];
      end
    end
  endgenerate

  // carry into the MSB, retimed to line up with the MSB slice result
  always_ff @(posedge TI) begin
    if (!RNI) begin
      msb_ci_dl <= '0;
    end else begin
      msb_ci_dl[0] <= c_c[WIDTH-2];
      for (int k = 1; k < STG; k++) msb_ci_dl[k] <= msb_ci_dl[k-1];
    end
  end

  always_ff @(posedge TI) begin
    if (!RNI) begin
      VO  <= 1'b0;
      SO  <= '0;
      CO  <= 1'b0;
      OVO <= 1'b0;
    end else begin
      VO <= v_c[WIDTH-1];
      if (v_c[WIDTH-1]) begin
        SO  <= s_al;
        CO  <= c_c[WIDTH-1];
        OVO <= c_c[WIDTH-1] ^ msb_ci_dl[STG-1];
      end
    end
  end
endmodule

// File: tb/tb_fa_pipe_n.sv
// Scoreboard bench for fa_pipe_n: an 8-bit STG=1 instance and a 16-bit STG=2 instance.
module tb_fa_pipe_n;
  import fa_pipe_pkg::*;

  localparam int LAT  = lat(8, 1);
  localparam int LAT2 = lat(16, 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn, vi, ci, sub, vo, co, ovo;
  logic [7:0]  a, b, so;
  logic        vi2, ci2, sub2, vo2, co2, ovo2;
  logic [15:0] a2, b2, so2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] so;
    logic       co;
    logic       ovo;
  } exp_t;
  exp_t q[$];

  fa_pipe_n #(.WIDTH(8), .STG(1)) dut (
    .TI(clk), .RNI(rn), .VI(vi), .AI(a), .BI(b), .CI(ci), .SUBI(sub),
    .VO(vo), .SO(so), .CO(co), .OVO(ovo)
  );

  fa_pipe_n #(.WIDTH(16), .STG(2)) dut2 (
    .TI(clk), .RNI(rn), .VI(vi2), .AI(a2), .BI(b2), .CI(ci2), .SUBI(sub2),
    .VO(vo2), .SO(so2), .CO(co2), .OVO(ovo2)
  );

  // Arithmetic reference: CO is carry for add, "no borrow" for sub.
  function automatic exp_t model(input logic [7:0] aa, bb, input logic c, s);
    exp_t e;
    int   ai, bi, ci_i;
    ai = int'(aa); bi = int'(bb); ci_i = c ? 1 : 0;
    if (!s) begin
      e.so  = 8'((ai + bi + ci_i) % 256);
      e.co  = (ai + bi + ci_i) > 255;
      e.ovo = (aa[7] == bb[7]) && (e.so[7] != aa[7]);
    end else begin
      e.so  = 8'((ai - bi - ci_i + 512) % 256);
      e.co  = ai >= (bi + ci_i);
      e.ovo = (aa[7] != bb[7]) && (e.so[7] != aa[7]);
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [7:0] aa, bb, input logic c, s);
    vi = v; a = aa; b = bb; ci = c; sub = s;
    if (v) q.push_back(model(aa, bb, c, s));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      q.delete();
      @(negedge clk);
      n_cmp++;
      if ({vo, so, co, ovo} !== 11'd0) begin
        n_bad++;
        $display("FAIL reset_state c=%0d got vo=%b so=%h co=%b ovo=%b want all 0", c, vo, so, co, ovo);
      end
      next_cycle();
    end
    rn = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (vo !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ignored c=%0d got vo=%b want 0", c, vo);
      end
      next_cycle();
    end
  endtask

  task automatic test_add();
    exp_t e;
    for (int c = 0; c < LAT + 4; c++) begin
      drive(c == 0, 8'h5A, 8'h33, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (vo !== (c == LAT)) begin
        n_bad++;
        $display("FAIL add_vo c=%0d got %b want %b", c, vo, c == LAT);
      end
      if (c == LAT) begin
        n_cmp++;
        if ({so, co, ovo} !== {8'h8D, 1'b0, 1'b1}) begin
          n_bad++;
          $display("FAIL add_const got so=%h co=%b ovo=%b want 8d 0 1", so, co, ovo);
        end
      end
      if (vo === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL add_sb unexpected output so=%h", so);
        end else begin
          e = q.pop_front();
          if ({so, co, ovo} !== {e.so, e.co, e.ovo}) begin
            n_bad++;
            $display("FAIL add_sb got %h/%b/%b want %h/%b/%b", so, co, ovo, e.so, e.co, e.ovo);
          end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_sub();
    exp_t e;
    for (int c = 0; c < LAT + 4; c++) begin
      if (c == 0)      drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
      else if (c == 1) drive(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
      else             drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (vo !== (c == LAT || c == LAT + 1)) begin
        n_bad++;
        $display("FAIL sub_vo c=%0d got %b", c, vo);
      end
      if (c == LAT) begin
        n_cmp++;
        if ({so, co, ovo} !== {8'hF0, 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL sub_borrow got so=%h co=%b ovo=%b want f0 0 0", so, co, ovo);
        end
      end
      if (c == LAT + 1) begin
        n_cmp++;
        if ({so, co, ovo} !== {8'h7F, 1'b1, 1'b1}) begin
          n_bad++;
          $display("FAIL sub_ovf got so=%h co=%b ovo=%b want 7f 1 1", so, co, ovo);
        end
      end
      if (vo === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL sub_sb unexpected output so=%h", so);
        end else begin
          e = q.pop_front();
          if ({so, co, ovo} !== {e.so, e.co, e.ovo}) begin
            n_bad++;
            $display("FAIL sub_sb got %h/%b/%b want %h/%b/%b", so, co, ovo, e.so, e.co, e.ovo);
          end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < LAT + 19; c++) begin
      if (c < 16) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      else        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (vo !== (c >= LAT && c < LAT + 16)) begin
        n_bad++;
        $display("FAIL stream_vo c=%0d got %b", c, vo);
      end
      if (vo === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_sb unexpected output so=%h", so);
        end else begin
          e = q.pop_front();
          if ({so, co, ovo} !== {e.so, e.co, e.ovo}) begin
            n_bad++;
            $display("FAIL stream_sb c=%0d got %h/%b/%b want %h/%b/%b", c, so, co, ovo, e.so, e.co, e.ovo);
          end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    for (int c = 0; c < LAT + 6; c++) begin
      if (c == 0)                drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
      else if (c == 2 || c == 3) drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      else                       drive(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (vo !== (c == LAT || c == LAT + 2 || c == LAT + 3)) begin
        n_bad++;
        $display("FAIL bubble_vo c=%0d got %b", c, vo);
      end
      if (c == LAT + 1) begin
        n_cmp++;
        if ({so, co, ovo} !== {8'h00, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL bubble_hold got so=%h co=%b ovo=%b want 00 1 0", so, co, ovo);
        end
      end
      if (c == LAT + 2) begin
        n_cmp++;
        if ({so, co} !== {8'h00, 1'b0}) begin
          n_bad++;
          $display("FAIL bubble_noleak got so=%h co=%b want 00 0", so, co);
        end
      end
      if (vo === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL bubble_sb unexpected output so=%h", so);
        end else begin
          e = q.pop_front();
          if ({so, co, ovo} !== {e.so, e.co, e.ovo}) begin
            n_bad++;
            $display("FAIL bubble_sb got %h/%b/%b want %h/%b/%b", so, co, ovo, e.so, e.co, e.ovo);
          end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    for (int c = 0; c < 18; c++) begin
      rn = (c != 5);
      if (c < 5)       drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      else if (c == 5) begin
        drive(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
        q.delete();
      end
      else if (c == 6) drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
      else             drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (vo !== (c == 15)) begin
        n_bad++;
        $display("FAIL rst_vo c=%0d got %b", c, vo);
      end
      if (c >= 6 && c < 15) begin
        n_cmp++;
        if ({so, co, ovo} !== 10'd0) begin
          n_bad++;
          $display("FAIL rst_flush c=%0d got so=%h co=%b ovo=%b want 0", c, so, co, ovo);
        end
      end
      if (vo === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rst_sb unexpected output so=%h", so);
        end else begin
          e = q.pop_front();
          if ({so, co, ovo} !== {e.so, e.co, e.ovo}) begin
            n_bad++;
            $display("FAIL rst_sb got %h/%b/%b want %h/%b/%b", so, co, ovo, e.so, e.co, e.ovo);
          end
        end
      end
      next_cycle();
    end
    rn = 1'b1;
  endtask

  task automatic test_stg2();
    for (int c = 0; c < LAT2 + 3; c++) begin
      vi2 = (c == 0); a2 = 16'hFFFF; b2 = 16'h0001; ci2 = 1'b1; sub2 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (vo2 !== (c == LAT2)) begin
        n_bad++;
        $display("FAIL stg2_vo c=%0d got %b want %b", c, vo2, c == LAT2);
      end
      if (c == LAT2) begin
        n_cmp++;
        if ({so2, co2, ovo2} !== {16'h0001, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL stg2_result got so=%h co=%b ovo=%b want 0001 1 0", so2, co2, ovo2);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    rn = 1'b0;
    vi = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    vi2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sub2 = 1'b0;
    next_cycle();
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_bubbles();
    test_mid_reset();
    test_stg2();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got %0d leftover want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
